// File: rtl/bg_scroll_fetch_pkg.sv
// Shared constants, FSM encoding and helpers for the scrolling background fetcher.
package bg_scroll_fetch_pkg;

    localparam int unsigned TILE_PX   = 8;
    localparam int unsigned FINE_W    = 3;
    localparam int unsigned PT_ADDR_W = 11;

    typedef enum logic [1:0] {StIdle, StNtReq, StPtReq, StWrite} fetch_state_e;

    function automatic int unsigned nt_addr_w(input int unsigned cols, input int unsigned rows);
        return $clog2(rows * cols / 4);
    endfunction

    function automatic int unsigned pix_code_w(input int unsigned entry_w);
        return 2 + entry_w - 8;
    endfunction

    // Four-stage restoring reduction; exact for any v < 16*m.
    function automatic logic [11:0] mod_sub(input logic [11:0] v, input int unsigned m);
        logic [11:0] r;
        r = v;
        for (int k = 3; k >= 0; k--) begin
            if (32'(r) >= (m << k)) r = r - 12'(m << k);
        end
        return r;
    endfunction

endpackage

// File: rtl/bg_line_buffer.sv
// Ping-pong line buffer: one write port, one registered read port, each with a bank select.
module bg_line_buffer
    import bg_scroll_fetch_pkg::*;
#(
    parameter int unsigned DEPTH = 33,
    parameter int unsigned PIX_W = 4,
    localparam int unsigned AW     = $clog2(DEPTH),
    localparam int unsigned WORD_W = TILE_PX * PIX_W
) (
    input  logic              clk,
    input  logic              we,
    input  logic              wr_bank,
    input  logic [AW-1:0]     wr_addr,
    input  logic [WORD_W-1:0] wr_data,
    input  logic              rd_bank,
    input  logic [AW-1:0]     rd_addr,
    output logic [WORD_W-1:0] rd_data
);

    logic [WORD_W-1:0] mem [2][DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[wr_bank][wr_addr] <= wr_data;
        rd_data <= mem[rd_bank][rd_addr];
    end

endmodule

// File: rtl/bg_scroll_fetch.sv
// Per-line background fetcher: nametable -> pattern -> line buffer, with pixel readout.
module bg_scroll_fetch
    import bg_scroll_fetch_pkg::*;
#(
    parameter int unsigned TILE_COLS  = 32,
    parameter int unsigned TILE_ROWS  = 30,
    parameter int unsigned ENTRY_W    = 10,
    parameter int unsigned LINE_TILES = 33,
    localparam int unsigned NT_AW = nt_addr_w(TILE_COLS, TILE_ROWS),
    localparam int unsigned PIX_W = pix_code_w(ENTRY_W)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   bg_enable,
    input  logic                   line_start,
    input  logic [8:0]             line_y,
    input  logic [8:0]             scroll_x,
    input  logic [8:0]             scroll_y,
    output logic                   nt_req,
    output logic [NT_AW-1:0]       nt_addr,
    input  logic                   nt_ack,
    input  logic [4*ENTRY_W-1:0]   nt_data,
    output logic                   pt_req,
    output logic [PT_ADDR_W-1:0]   pt_addr,
    input  logic                   pt_ack,
    input  logic [15:0]            pt_data,
    input  logic [7:0]             pix_x,
    output logic [PIX_W-1:0]       pix_code,
    output logic                   fetch_done,
    output logic                   fetch_overrun
);

    localparam int unsigned TW     = $clog2(LINE_TILES);
    localparam int unsigned CW     = $clog2(TILE_COLS);
    localparam int unsigned WY_W   = $clog2(TILE_ROWS * TILE_PX);
    localparam int unsigned WORD_W = TILE_PX * PIX_W;

    fetch_state_e             state_q, state_d;
    logic [TW-1:0]            t_q, t_d;
    logic [CW-1:0]            col_q, col_d, col_inc;
    logic [WY_W-1:0]          wy_q, wy_d, wy_new;
    logic [CW-1:0]            cx_new;
    logic [FINE_W-1:0]        fine_back_q, fine_back_d, fine_front_q, fine_front_d;
    logic                     front_q, front_d;
    logic [NT_AW-1:0]         nt_addr_q, nt_addr_d;
    logic [PT_ADDR_W-1:0]     pt_addr_q, pt_addr_d;
    logic [4*ENTRY_W-1:0]     cache_q, cache_d;
    logic [15:0]              pt_q, pt_d;
    logic                     done_q, done_d, overrun_q, overrun_d;
    logic                     en_q;
    logic [2:0]               sel_q;
    logic                     we;
    logic [ENTRY_W-1:0]       cur_entry;
    logic [WORD_W-1:0]        wr_word, rd_word;
    logic [8:0]               rd_p;
    logic [11:0]              wy_full, cx_full;

    // Entry 0 sits in the MSBs of the nametable word.
    function automatic logic [ENTRY_W-1:0] entry_sel(input logic [4*ENTRY_W-1:0] word,
                                                     input logic [1:0] idx);
        return word[(3 - 32'(idx)) * ENTRY_W +: ENTRY_W];
    endfunction

    function automatic logic [NT_AW-1:0] nt_addr_of(input logic [WY_W-1:0] wy,
                                                    input logic [CW-1:0] col);
        return NT_AW'(32'(wy >> 3) * (TILE_COLS / 4) + 32'(col >> 2));
    endfunction

    function automatic logic [PT_ADDR_W-1:0] pt_addr_of(input logic [ENTRY_W-1:0] entry,
                                                        input logic [WY_W-1:0] wy);
        return {entry[7:0], wy[2:0]};
    endfunction

    assign wy_full   = mod_sub(12'(line_y) + 12'(scroll_y), TILE_ROWS * TILE_PX);
    assign cx_full   = mod_sub(12'(scroll_x[8:3]), TILE_COLS);
    assign wy_new    = WY_W'(wy_full);
    assign cx_new    = CW'(cx_full);
    assign col_inc   = (col_q == CW'(TILE_COLS - 1)) ? '0 : col_q + CW'(1);
    assign cur_entry = entry_sel(cache_q, col_q[1:0]);

    always_comb begin
        state_d      = state_q;
        t_d          = t_q;
        col_d        = col_q;
        wy_d         = wy_q;
        fine_back_d  = fine_back_q;
        fine_front_d = fine_front_q;
        front_d      = front_q;
        nt_addr_d    = nt_addr_q;
        pt_addr_d    = pt_addr_q;
        cache_d      = cache_q;
        pt_d         = pt_q;
        done_d       = 1'b0;
        overrun_d    = 1'b0;
        we           = 1'b0;
        unique case (state_q)
            StIdle: ;
            StNtReq: begin
                if (nt_ack) begin
                    cache_d   = nt_data;
                    pt_addr_d = pt_addr_of(entry_sel(nt_data, col_q[1:0]), wy_q);
                    state_d   = StPtReq;
                end
            end
            StPtReq: begin
                if (pt_ack) begin
                    pt_d    = pt_data;
                    state_d = StWrite;
                end
            end
            StWrite: begin
                we = 1'b1;
                if (t_q == TW'(LINE_TILES - 1)) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                end else begin
                    t_d   = t_q + TW'(1);
                    col_d = col_inc;
                    if (col_inc[1:0] == 2'd0) begin
                        nt_addr_d = nt_addr_of(wy_q, col_inc);
                        state_d   = StNtReq;
                    end else begin
                        pt_addr_d = pt_addr_of(entry_sel(cache_q, col_inc[1:0]), wy_q);
                        state_d   = StPtReq;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
        // A new line always wins: swap banks, drop any outstanding request, restart.
        if (line_start) begin
            front_d      = ~front_q;
            fine_front_d = fine_back_q;
            fine_back_d  = scroll_x[2:0];
            overrun_d    = (state_q != StIdle);
            done_d       = 1'b0;
            we           = 1'b0;
            state_d      = StIdle;
            if (bg_enable) begin
                state_d   = StNtReq;
                t_d       = '0;
                col_d     = cx_new;
                wy_d      = wy_new;
                nt_addr_d = nt_addr_of(wy_new, cx_new);
            end
        end
    end

    always_comb begin
        wr_word = '0;
        for (int i = 0; i < TILE_PX; i++) begin
            wr_word[i*PIX_W +: PIX_W] = {cur_entry[ENTRY_W-1:8], pt_q[15-i], pt_q[7-i]};
        end
    end

    assign rd_p = 9'(pix_x) + 9'(fine_front_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            t_q          <= '0;
            col_q        <= '0;
            wy_q         <= '0;
            fine_back_q  <= '0;
            fine_front_q <= '0;
            front_q      <= 1'b0;
            nt_addr_q    <= '0;
            pt_addr_q    <= '0;
            cache_q      <= '0;
            pt_q         <= '0;
            done_q       <= 1'b0;
            overrun_q    <= 1'b0;
            en_q         <= 1'b0;
            sel_q        <= '0;
        end else begin
            state_q      <= state_d;
            t_q          <= t_d;
            col_q        <= col_d;
            wy_q         <= wy_d;
            fine_back_q  <= fine_back_d;
            fine_front_q <= fine_front_d;
            front_q      <= front_d;
            nt_addr_q    <= nt_addr_d;
            pt_addr_q    <= pt_addr_d;
            cache_q      <= cache_d;
            pt_q         <= pt_d;
            done_q       <= done_d;
            overrun_q    <= overrun_d;
            en_q         <= bg_enable;
            sel_q        <= rd_p[2:0];
        end
    end

    bg_line_buffer #(
        .DEPTH (LINE_TILES),
        .PIX_W (PIX_W)
    ) u_line_buffer (
        .clk     (clk),
        .we      (we),
        .wr_bank (~front_q),
        .wr_addr (t_q),
        .wr_data (wr_word),
        .rd_bank (front_q),
        .rd_addr (TW'(rd_p[8:3])),
        .rd_data (rd_word)
    );

    assign nt_req        = (state_q == StNtReq);
    assign pt_req        = (state_q == StPtReq);
    assign nt_addr       = nt_addr_q;
    assign pt_addr       = pt_addr_q;
    assign fetch_done    = done_q;
    assign fetch_overrun = overrun_q;
    assign pix_code      = en_q ? rd_word[32'(sel_q)*PIX_W +: PIX_W] : '0;

endmodule

// File: tb/tb_bg_scroll_fetch.sv
// Directed bench for bg_scroll_fetch with simple nametable/pattern responders.
module tb_bg_scroll_fetch;

    logic        clk = 1'b0;
    logic        rst, bg_enable, line_start;
    logic [8:0]  line_y, scroll_x, scroll_y;
    logic        nt_req, nt_ack, pt_req, pt_ack;
    logic [7:0]  nt_addr;
    logic [39:0] nt_data;
    logic [10:0] pt_addr;
    logic [15:0] pt_data;
    logic [7:0]  pix_x;
    logic [3:0]  pix_code;
    logic        fetch_done, fetch_overrun;

    int   n_cmp = 0;
    int   n_fail = 0;
    int   nt_cnt = 0;
    int   pt_cnt = 0;
    int   done_cnt = 0;
    logic nt_hold = 1'b0, pt_hold = 1'b0, nt_force = 1'b0;
    int   nt_log[$];
    int   pt_log[$];

    always #5 clk = ~clk;

    bg_scroll_fetch dut (
        .clk           (clk),
        .rst           (rst),
        .bg_enable     (bg_enable),
        .line_start    (line_start),
        .line_y        (line_y),
        .scroll_x      (scroll_x),
        .scroll_y      (scroll_y),
        .nt_req        (nt_req),
        .nt_addr       (nt_addr),
        .nt_ack        (nt_ack),
        .nt_data       (nt_data),
        .pt_req        (pt_req),
        .pt_addr       (pt_addr),
        .pt_ack        (pt_ack),
        .pt_data       (pt_data),
        .pix_x         (pix_x),
        .pix_code      (pix_code),
        .fetch_done    (fetch_done),
        .fetch_overrun (fetch_overrun)
    );

    // Nametable word a, entry k: tile = 4a+k+1, palette = (a+k)&3.
    function automatic logic [39:0] nt_word(input logic [7:0] a);
        logic [39:0] w;
        int tile, pal;
        w = '0;
        for (int k = 0; k < 4; k++) begin
            tile = (32'(a) * 4 + k + 1) & 255;
            pal  = (32'(a) + k) & 3;
            w[(3-k)*10 +: 10] = {2'(pal), 8'(tile)};
        end
        return w;
    endfunction

    // Pattern row: plane0 = tile, plane1 = {tile[3:0], row, 1}.
    function automatic logic [15:0] pt_word(input logic [10:0] a);
        logic [7:0] tile;
        tile = a[10:3];
        return {tile[3:0], a[2:0], 1'b1, tile};
    endfunction

    assign nt_data = nt_word(nt_addr);
    assign pt_data = pt_word(pt_addr);
    assign nt_ack  = nt_force | (nt_req & ~nt_hold & (nt_cnt >= 1));
    assign pt_ack  = pt_req & ~pt_hold & (pt_cnt >= 1);

    always @(posedge clk) begin
        nt_cnt <= nt_req ? nt_cnt + 1 : 0;
        pt_cnt <= pt_req ? pt_cnt + 1 : 0;
        if (nt_req && nt_ack) nt_log.push_back(32'(nt_addr));
        if (pt_req && pt_ack) pt_log.push_back(32'(pt_addr));
        if (fetch_done) done_cnt <= done_cnt + 1;
    end

    task automatic start_line(input int sx, input int sy, input int ly);
        scroll_x   = 9'(sx);
        scroll_y   = 9'(sy);
        line_y     = 9'(ly);
        bg_enable  = 1'b1;
        line_start = 1'b1;
        @(negedge clk);
        line_start = 1'b0;
    endtask

    task automatic wait_done(input int base, output bit ok);
        int n;
        n = 0;
        while (done_cnt == base && n < 1000) begin
            @(negedge clk);
            n++;
        end
        ok = (done_cnt != base);
    endtask

    // Swap banks without starting a fetch, then re-enable output.
    task automatic show();
        bg_enable  = 1'b0;
        line_start = 1'b1;
        @(negedge clk);
        line_start = 1'b0;
        bg_enable  = 1'b1;
    endtask

    task automatic read_pix(input int px, output logic [3:0] code);
        pix_x = 8'(px);
        @(negedge clk);
        code = pix_code;
    endtask

    task automatic run_line(input int sx, input int sy, input int ly, output bit ok);
        int base;
        nt_log.delete();
        pt_log.delete();
        base = done_cnt;
        start_line(sx, sy, ly);
        wait_done(base, ok);
    endtask

    task automatic test_reset();
        n_cmp++; if (nt_req !== 1'b0) begin n_fail++; $display("FAIL reset_nt_req: got %0b want 0", nt_req); end
        n_cmp++; if (pt_req !== 1'b0) begin n_fail++; $display("FAIL reset_pt_req: got %0b want 0", pt_req); end
        n_cmp++; if (nt_addr !== 8'd0) begin n_fail++; $display("FAIL reset_nt_addr: got %0d want 0", nt_addr); end
        n_cmp++; if (pt_addr !== 11'd0) begin n_fail++; $display("FAIL reset_pt_addr: got %0d want 0", pt_addr); end
        n_cmp++; if (fetch_done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %0b want 0", fetch_done); end
        n_cmp++; if (fetch_overrun !== 1'b0) begin n_fail++; $display("FAIL reset_overrun: got %0b want 0", fetch_overrun); end
        n_cmp++; if (pix_code !== 4'd0) begin n_fail++; $display("FAIL reset_pix: got %0d want 0", pix_code); end
    endtask

    task automatic test_basic();
        bit ok;
        int base;
        logic [3:0] code;
        logic [3:0] exp_row [8];
        exp_row = '{4'd0, 4'd0, 4'd0, 4'd2, 4'd0, 4'd0, 4'd0, 4'd3};
        base = done_cnt;
        run_line(0, 0, 0, ok);
        repeat (3) @(negedge clk);
        n_cmp++; if (!ok) begin n_fail++; $display("FAIL basic_done_wait: got timeout want fetch_done"); end
        n_cmp++; if (done_cnt - base != 1) begin n_fail++; $display("FAIL basic_done_pulses: got %0d want 1", done_cnt - base); end
        n_cmp++; if (nt_log.size() != 9) begin n_fail++; $display("FAIL basic_nt_count: got %0d want 9", nt_log.size()); end
        n_cmp++; if (pt_log.size() != 33) begin n_fail++; $display("FAIL basic_pt_count: got %0d want 33", pt_log.size()); end
        n_cmp++; if ((pt_log.size() > 0 ? pt_log[0] : -1) != 8) begin n_fail++; $display("FAIL basic_pt_addr0: got %0d want 8", pt_log.size() > 0 ? pt_log[0] : -1); end
        show();
        for (int i = 0; i < 8; i++) begin
            read_pix(i, code);
            n_cmp++; if (code !== exp_row[i]) begin n_fail++; $display("FAIL basic_pix%0d: got %0d want %0d", i, code, exp_row[i]); end
        end
        read_pix(255, code);
        n_cmp++; if (code !== 4'd10) begin n_fail++; $display("FAIL basic_pix255: got %0d want 10", code); end
    endtask

    task automatic test_fine_scroll();
        bit ok;
        logic [3:0] code;
        int px [5];
        logic [3:0] exp_c [5];
        px    = '{0, 2, 3, 5, 9};
        exp_c = '{4'd0, 4'd3, 4'd4, 4'd6, 4'd5};
        run_line(5, 0, 0, ok);
        n_cmp++; if (!ok) begin n_fail++; $display("FAIL fine_done_wait: got timeout want fetch_done"); end
        show();
        for (int i = 0; i < 5; i++) begin
            read_pix(px[i], code);
            n_cmp++; if (code !== exp_c[i]) begin n_fail++; $display("FAIL fine_pix%0d: got %0d want %0d", px[i], code, exp_c[i]); end
        end
    endtask

    task automatic test_wrap();
        bit ok;
        logic [3:0] code;
        run_line(252, 0, 0, ok);
        n_cmp++; if (!ok) begin n_fail++; $display("FAIL wrap_done_wait: got timeout want fetch_done"); end
        n_cmp++; if ((nt_log.size() > 0 ? nt_log[0] : -1) != 7) begin n_fail++; $display("FAIL wrap_nt0: got %0d want 7", nt_log.size() > 0 ? nt_log[0] : -1); end
        n_cmp++; if ((nt_log.size() > 1 ? nt_log[1] : -1) != 0) begin n_fail++; $display("FAIL wrap_nt1: got %0d want 0", nt_log.size() > 1 ? nt_log[1] : -1); end
        n_cmp++; if (nt_log.size() != 9) begin n_fail++; $display("FAIL wrap_nt_count: got %0d want 9", nt_log.size()); end
        n_cmp++; if ((pt_log.size() > 32 ? pt_log[32] : -1) != 256) begin n_fail++; $display("FAIL wrap_pt32: got %0d want 256", pt_log.size() > 32 ? pt_log[32] : -1); end
        show();
        read_pix(0, code);
        n_cmp++; if (code !== 4'd8) begin n_fail++; $display("FAIL wrap_pix0: got %0d want 8", code); end
        read_pix(7, code);
        n_cmp++; if (code !== 4'd2) begin n_fail++; $display("FAIL wrap_pix7: got %0d want 2", code); end
        read_pix(251, code);
        n_cmp++; if (code !== 4'd7) begin n_fail++; $display("FAIL wrap_pix251: got %0d want 7", code); end
    endtask

    task automatic test_vscroll();
        bit ok;
        int sy [3];
        int ly [3];
        int exp_nt [3];
        int exp_pt [3];
        sy     = '{16, 0, 511};
        ly     = '{230, 20, 239};
        exp_nt = '{0, 16, 24};
        exp_pt = '{14, 524, 782};
        for (int i = 0; i < 3; i++) begin
            run_line(0, sy[i], ly[i], ok);
            n_cmp++; if (!ok) begin n_fail++; $display("FAIL vscroll%0d_done_wait: got timeout want fetch_done", i); end
            n_cmp++; if ((nt_log.size() > 0 ? nt_log[0] : -1) != exp_nt[i]) begin n_fail++; $display("FAIL vscroll%0d_nt: got %0d want %0d", i, nt_log.size() > 0 ? nt_log[0] : -1, exp_nt[i]); end
            n_cmp++; if ((pt_log.size() > 0 ? pt_log[0] : -1) != exp_pt[i]) begin n_fail++; $display("FAIL vscroll%0d_pt: got %0d want %0d", i, pt_log.size() > 0 ? pt_log[0] : -1, exp_pt[i]); end
        end
    endtask

    task automatic test_overrun();
        bit ok;
        int n;
        int base;
        pt_hold = 1'b1;
        start_line(0, 0, 0);
        n = 0;
        while (!pt_req && n < 50) begin
            @(negedge clk);
            n++;
        end
        n_cmp++; if (pt_req !== 1'b1) begin n_fail++; $display("FAIL overrun_pt_wait: got %0b want 1", pt_req); end
        nt_log.delete();
        pt_log.delete();
        base = done_cnt;
        start_line(252, 0, 0);
        n_cmp++; if (fetch_overrun !== 1'b1) begin n_fail++; $display("FAIL overrun_pulse: got %0b want 1", fetch_overrun); end
        n_cmp++; if (pt_req !== 1'b0) begin n_fail++; $display("FAIL overrun_pt_drop: got %0b want 0", pt_req); end
        n_cmp++; if (nt_req !== 1'b1) begin n_fail++; $display("FAIL overrun_restart: got %0b want 1", nt_req); end
        n_cmp++; if (nt_addr !== 8'd7) begin n_fail++; $display("FAIL overrun_nt_addr: got %0d want 7", nt_addr); end
        @(negedge clk);
        n_cmp++; if (fetch_overrun !== 1'b0) begin n_fail++; $display("FAIL overrun_one_cycle: got %0b want 0", fetch_overrun); end
        pt_hold = 1'b0;
        wait_done(base, ok);
        n_cmp++; if (!ok) begin n_fail++; $display("FAIL overrun_done_wait: got timeout want fetch_done"); end
        n_cmp++; if (pt_log.size() != 33) begin n_fail++; $display("FAIL overrun_pt_count: got %0d want 33", pt_log.size()); end
    endtask

    task automatic test_disable();
        bit ok;
        bit saw;
        int base;
        logic [3:0] code;
        bg_enable  = 1'b0;
        line_start = 1'b1;
        @(negedge clk);
        line_start = 1'b0;
        saw = 1'b0;
        repeat (5) begin
            if (nt_req) saw = 1'b1;
            @(negedge clk);
        end
        n_cmp++; if (saw !== 1'b0) begin n_fail++; $display("FAIL disable_no_fetch: got %0b want 0", saw); end
        base = done_cnt;
        start_line(0, 0, 0);
        repeat (4) @(negedge clk);
        bg_enable = 1'b0;
        wait_done(base, ok);
        n_cmp++; if (!ok) begin n_fail++; $display("FAIL disable_completes: got timeout want fetch_done"); end
        read_pix(3, code);
        n_cmp++; if (code !== 4'd0) begin n_fail++; $display("FAIL disable_pix_forced: got %0d want 0", code); end
        bg_enable = 1'b1;
    endtask

    task automatic test_reset_mid();
        bit saw;
        int base;
        nt_hold = 1'b1;
        start_line(0, 0, 0);
        n_cmp++; if (nt_req !== 1'b1) begin n_fail++; $display("FAIL rstmid_nt_req: got %0b want 1", nt_req); end
        base = done_cnt;
        rst = 1'b1;
        @(negedge clk);
        n_cmp++; if (nt_req !== 1'b0) begin n_fail++; $display("FAIL rstmid_nt_drop: got %0b want 0", nt_req); end
        n_cmp++; if (nt_addr !== 8'd0) begin n_fail++; $display("FAIL rstmid_nt_addr: got %0d want 0", nt_addr); end
        n_cmp++; if (pix_code !== 4'd0) begin n_fail++; $display("FAIL rstmid_pix: got %0d want 0", pix_code); end
        rst      = 1'b0;
        nt_hold  = 1'b0;
        nt_force = 1'b1;
        saw = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (pt_req || nt_req) saw = 1'b1;
        end
        nt_force = 1'b0;
        n_cmp++; if (saw !== 1'b0) begin n_fail++; $display("FAIL rstmid_late_ack: got %0b want 0", saw); end
        n_cmp++; if (done_cnt != base) begin n_fail++; $display("FAIL rstmid_no_done: got %0d want %0d", done_cnt, base); end
    endtask

    task automatic test_back_to_back();
        bit ok1, ok2;
        logic [3:0] code;
        run_line(5, 0, 0, ok1);
        run_line(0, 0, 0, ok2);
        n_cmp++; if (!(ok1 && ok2)) begin n_fail++; $display("FAIL b2b_done_wait: got %0b%0b want 11", ok1, ok2); end
        show();
        read_pix(3, code);
        n_cmp++; if (code !== 4'd2) begin n_fail++; $display("FAIL b2b_pix3: got %0d want 2", code); end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst        = 1'b1;
        bg_enable  = 1'b0;
        line_start = 1'b0;
        line_y     = '0;
        scroll_x   = '0;
        scroll_y   = '0;
        pix_x      = '0;
        repeat (3) @(negedge clk);
        test_reset();
        rst = 1'b0;
        @(negedge clk);
        test_basic();
        test_fine_scroll();
        test_wrap();
        test_vscroll();
        test_overrun();
        test_disable();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
